// File: rtl/leg_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : leg_fetch_pkg
// Purpose : Shared types and constants for the instruction prefetch queue.
//           fetch_entry_t pairs a fetched instruction word with its address.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package leg_fetch_pkg;

  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] LEG_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Forces a byte address onto a word boundary.
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & ~32'(WORD_BYTES - 1);
  endfunction

endpackage : leg_fetch_pkg
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : prefetch_fifo
// Purpose : Synchronous FIFO of fetch_entry_t with a synchronous clear.
//           The head entry is read straight out of the storage array, so it
//           is available in the cycle after the push that wrote it.
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           i_Push/i_PushEntry - write one entry (caller guarantees room or
//                                a simultaneous pop)
//           i_Pop              - remove the head entry (ignored when empty)
//           i_Clear            - discard all entries; overrides push and pop
//           o_HeadEntry        - current head (undefined when empty)
//           o_Full, o_Empty    - occupancy flags
//           o_Count            - occupancy, $clog2(DEPTH)+1 bits
// Revision: 1.0 - initial release
// ============================================================================
module prefetch_fifo
  import leg_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_Push,
  input  fetch_entry_t             i_PushEntry,
  input  logic                     i_Pop,
  input  logic                     i_Clear,
  output fetch_entry_t             o_HeadEntry,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  r_Mem [DEPTH];
  logic [PW-1:0] r_WrPtr;
  logic [PW-1:0] r_RdPtr;
  logic [CW-1:0] r_Count;

  logic w_DoPush;
  logic w_DoPop;

  assign w_DoPop  = i_Pop & (r_Count != '0);
  assign w_DoPush = i_Push;

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_WrPtr <= '0;
      r_RdPtr <= '0;
      r_Count <= '0;
    end else if (i_Clear) begin
      r_WrPtr <= '0;
      r_RdPtr <= '0;
      r_Count <= '0;
    end else begin
      if (w_DoPush) r_WrPtr <= r_WrPtr + PW'(1);
      if (w_DoPop)  r_RdPtr <= r_RdPtr + PW'(1);
      r_Count <= r_Count + CW'(w_DoPush) - CW'(w_DoPop);
    end
  end

  // Storage needs no reset: nothing is read from a slot before it is written.
  always_ff @(posedge clk) begin
    if (w_DoPush && !i_Clear) r_Mem[r_WrPtr] <= i_PushEntry;
  end

  assign o_HeadEntry = r_Mem[r_RdPtr];
  assign o_Count     = r_Count;
  assign o_Empty     = (r_Count == '0);
  assign o_Full      = (r_Count == CW'(DEPTH));

endmodule : prefetch_fifo
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_prefetch_queue
// Purpose : Instruction prefetch buffer between instruction memory and the
//           decode pipeline register. Issues sequential word fetches,
//           buffers in-order responses and presents the head entry with its
//           PC to decode. A redirect flushes the buffer, restarts fetching at
//           the target and silently drops responses still in flight.
// Config  : LEG_PREFETCH_BYPASS_EN - when defined, a response arriving into
//           an empty queue is forwarded combinationally to the decode outputs.
// Ports   : clk, reset (async, active-low)
//           RedirectE, RedirectPCE      - redirect request and target
//           StallD                      - decode not accepting
//           IReqValidF/IReqAddrF/IReqReadyF - fetch request channel
//           IRespValidF/IRespDataF      - in-order fetch responses
//           InstrValidF/InstrF/InstrPCF - head entry for decode (0 when empty)
//           QueueEmptyF                 - no buffered entries
// Revision: 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue
  import leg_fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_VECTOR    = LEG_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPCE,
  input  logic        StallD,
  output logic        IReqValidF,
  output logic [31:0] IReqAddrF,
  input  logic        IReqReadyF,
  input  logic        IRespValidF,
  input  logic [31:0] IRespDataF,
  output logic        InstrValidF,
  output logic [31:0] InstrF,
  output logic [31:0] InstrPCF,
  output logic        QueueEmptyF
);

  localparam int CW  = $clog2(DEPTH) + 1;
  // Drop counter has headroom for several back-to-back redirects.
  localparam int DCW = CW + 4;

  logic [31:0]    r_FetchPC;
  logic [31:0]    r_RespPC;
  logic [CW-1:0]  r_Outstanding;
  logic [DCW-1:0] r_DropCount;

  fetch_entry_t   w_Head;
  fetch_entry_t   w_PushEntry;
  logic           w_Full;
  logic           w_Empty;
  logic [CW-1:0]  w_Count;

  logic           w_Dropping;
  logic           w_CreditOk;
  logic           w_Accept;
  logic           w_RespLive;
  logic           w_BypassTaken;
  logic           w_Push;
  logic           w_Pop;
  logic [31:0]    w_RedirectPC;

  assign w_RedirectPC = wordAlign(RedirectPCE);
  assign w_Dropping   = (r_DropCount != '0);

  // A request is only issued when the queue has a slot reserved for its
  // response and the memory-side outstanding limit is not reached.
  assign w_CreditOk = (({1'b0, w_Count} + {1'b0, r_Outstanding}) < (CW + 1)'(DEPTH))
                    & (r_Outstanding < CW'(MAX_OUTSTANDING));

  // Gated by reset so the request channel is idle while reset is held.
  assign IReqValidF = reset & ~RedirectE & w_CreditOk;
  assign IReqAddrF  = r_FetchPC;
  assign w_Accept   = IReqValidF & IReqReadyF;

  // A live response is one that belongs to the current fetch stream.
  assign w_RespLive = IRespValidF & ~w_Dropping & ~RedirectE;

  assign w_Pop       = ~w_Empty & ~StallD & ~RedirectE;
  assign w_Push      = w_RespLive & ~w_BypassTaken & (~w_Full | w_Pop);
  assign w_PushEntry = '{pc: r_RespPC, instr: IRespDataF};

`ifdef LEG_PREFETCH_BYPASS_EN
  logic w_Bypass;
  assign w_Bypass      = w_Empty & w_RespLive;
  assign w_BypassTaken = w_Bypass & ~StallD;

  always_comb begin
    InstrValidF = 1'b0;
    InstrF      = '0;
    InstrPCF    = '0;
    if (!w_Empty) begin
      InstrValidF = 1'b1;
      InstrF      = w_Head.instr;
      InstrPCF    = w_Head.pc;
    end else if (w_Bypass) begin
      InstrValidF = 1'b1;
      InstrF      = IRespDataF;
      InstrPCF    = r_RespPC;
    end
  end
`else
  assign w_BypassTaken = 1'b0;

  always_comb begin
    InstrValidF = 1'b0;
    InstrF      = '0;
    InstrPCF    = '0;
    if (!w_Empty) begin
      InstrValidF = 1'b1;
      InstrF      = w_Head.instr;
      InstrPCF    = w_Head.pc;
    end
  end
`endif

  assign QueueEmptyF = w_Empty;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_Push      (w_Push),
    .i_PushEntry (w_PushEntry),
    .i_Pop       (w_Pop),
    .i_Clear     (RedirectE),
    .o_HeadEntry (w_Head),
    .o_Full      (w_Full),
    .o_Empty     (w_Empty),
    .o_Count     (w_Count)
  );

  // On a redirect every request still in flight, plus any already marked
  // for dropping, is moved into DropCount; the response arriving in the
  // redirect cycle (if any) is consumed from that total right away.
  // Outstanding then only tracks requests of the new stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_FetchPC     <= RESET_VECTOR;
      r_RespPC      <= RESET_VECTOR;
      r_Outstanding <= '0;
      r_DropCount   <= '0;
    end else if (RedirectE) begin
      r_FetchPC     <= w_RedirectPC;
      r_RespPC      <= w_RedirectPC;
      r_Outstanding <= '0;
      r_DropCount   <= r_DropCount + DCW'(r_Outstanding) - DCW'(IRespValidF);
    end else begin
      if (w_Accept)   r_FetchPC <= r_FetchPC + 32'(WORD_BYTES);
      if (w_RespLive) r_RespPC  <= r_RespPC + 32'(WORD_BYTES);
      r_Outstanding <= r_Outstanding + CW'(w_Accept) - CW'(IRespValidF & ~w_Dropping);
      if (IRespValidF && w_Dropping) r_DropCount <= r_DropCount - DCW'(1);
    end
  end

endmodule : fetch_prefetch_queue
`default_nettype wire
